// File: rtl/tdm_demux.sv
// Purpose: TDM slot demultiplexer; hunts for frame_sync, collects CH slots, publishes whole frames on y.
// Latency: y and frame_done update 1 edge after the final slot of a frame is accepted.
// Backpressure: none; one slot per cycle is accepted, din_valid=0 cycles simply stall the slot counter.
module tdm_demux #(
    parameter int CH = 4,
    parameter int W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           din,
    input  logic                   din_valid,
    input  logic                   frame_sync,
    output logic [CH*W-1:0]        y,
    output logic [$clog2(CH)-1:0]  sel,
    output logic                   locked,
    output logic                   frame_done,
    output logic                   sync_err
);

    localparam int SELW = $clog2(CH);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(CH - 1);
    localparam logic [SELW-1:0] SEL_ONE  = SELW'(1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [W-1:0]     shadow_q [CH-1];
    logic [CH*W-1:0]  y_q;
    logic             frame_done_q, frame_done_d;
    logic             sync_err_q, sync_err_d;
    logic             shadow_we;
    logic [SELW-1:0]  shadow_idx;
    logic             load_y;
    logic [CH*W-1:0]  y_next;

    // Next-state and per-beat actions; invalid beats leave everything untouched.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        shadow_we    = 1'b0;
        shadow_idx   = sel_q;
        load_y       = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_we  = 1'b1;
                        shadow_idx = '0;
                        sel_d      = SEL_ONE;
                        state_d    = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // A sync anywhere but slot 0 abandons the partial frame and restarts it.
                        sync_err_d = (sel_q != '0);
                        shadow_we  = 1'b1;
                        shadow_idx = '0;
                        sel_d      = SEL_ONE;
                    end else if (sel_q == '0) begin
                        // Expected a frame start but got none: framing is lost.
                        sync_err_d = 1'b1;
                        sel_d      = '0;
                        state_d    = HUNT;
                    end else if (sel_q == SEL_LAST) begin
                        load_y       = 1'b1;
                        frame_done_d = 1'b1;
                        sel_d        = '0;
                    end else begin
                        shadow_we = 1'b1;
                        sel_d     = sel_q + SEL_ONE;
                    end
                end
                default: begin
                    state_d = HUNT;
                    sel_d   = '0;
                end
            endcase
        end
    end

    // Full frame image: shadow slots plus the final slot straight from din.
    always_comb begin
        y_next = '0;
        for (int k = 0; k < CH - 1; k++) begin
            y_next[k*W +: W] = shadow_q[k];
        end
        y_next[(CH-1)*W +: W] = din;
    end

    // Control state, slot counter and output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            sel_q        <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // Shadow slots collect a frame in progress; only a completed frame is copied to y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CH - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (shadow_we) begin
            for (int k = 0; k < CH - 1; k++) begin
                if (shadow_idx == SELW'(k)) begin
                    shadow_q[k] <= din;
                end
            end
        end
    end

    // Output frame register, updated atomically at frame completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else if (load_y) begin
            y_q <= y_next;
        end
    end

    assign y          = y_q;
    assign sel        = sel_q;
    assign locked     = (state_q == LOCKED);
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Purpose: scoreboard bench for tdm_demux with CH=4, W=8 directed frames.
// Latency: expected frames are matched against y on each frame_done pulse.
// Backpressure: not applicable; stimulus drives one beat per clock.
module tb_tdm_demux;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk;
    logic            rst;
    logic [W-1:0]    din;
    logic            din_valid;
    logic            frame_sync;
    logic [CH*W-1:0] y;
    logic [1:0]      sel;
    logic            locked;
    logic            frame_done;
    logic            sync_err;

    int checks   = 0;
    int failures = 0;

    logic [CH*W-1:0] exp_frame_q[$];
    bit              exp_err_q[$];

    tdm_demux #(.CH(CH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .y          (y),
        .sel        (sel),
        .locked     (locked),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must always terminate.
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; returns 1ns after the sampling edge.
    task automatic drive(input logic [W-1:0] d, input logic v, input logic s);
        din        = d;
        din_valid  = v;
        frame_sync = s;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic s);
        drive(d, 1'b1, s);
    endtask

    task automatic idle();
        drive(8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: every pulse must match an expectation queued by the stimulus.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) begin
                checks++;
                if (exp_frame_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_frame_done: actual y=0x%0h required=no frame", y);
                end else begin
                    logic [CH*W-1:0] e;
                    e = exp_frame_q.pop_front();
                    if (y !== e) begin
                        failures++;
                        $display("FAIL frame_y: actual=0x%0h required=0x%0h", y, e);
                    end
                end
            end
            if (sync_err) begin
                checks++;
                if (exp_err_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_sync_err: actual=1 required=0");
                end else begin
                    void'(exp_err_q.pop_front());
                end
            end
            if (frame_done && sync_err) begin
                checks++;
                failures++;
                $display("FAIL pulse_exclusive: actual=both high required=at most one");
            end
        end
    end

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        #1;
        chk("reset_y", y, 0);
        chk("reset_locked", locked, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Clean frame
        exp_frame_q.push_back(32'h44332211);
        beat(8'h11, 1'b1);
        chk("clean_sel_after_sync", sel, 1);
        chk("clean_locked_after_sync", locked, 1);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        chk("clean_y_not_partial", y, 0);
        beat(8'h44, 1'b0);
        chk("clean_y", y, 32'h44332211);
        chk("clean_frame_done", frame_done, 1);
        chk("clean_sel_wrap", sel, 0);
        chk("clean_locked", locked, 1);
        idle();
        chk("clean_frame_done_one_cycle", frame_done, 0);

        // Gapped frame
        exp_frame_q.push_back(32'h44332211);
        beat(8'h11, 1'b1);
        idle();
        chk("gap_sel_hold", sel, 1);
        beat(8'h22, 1'b0);
        idle();
        idle();
        chk("gap_sel_hold2", sel, 2);
        beat(8'h33, 1'b0);
        idle();
        beat(8'h44, 1'b0);
        chk("gap_y", y, 32'h44332211);
        chk("gap_frame_done", frame_done, 1);

        // Early sync
        beat(8'hA1, 1'b1);
        beat(8'hA2, 1'b0);
        exp_err_q.push_back(1'b1);
        exp_frame_q.push_back(32'hB4B3B2B1);
        beat(8'hB1, 1'b1);
        chk("early_sync_err", sync_err, 1);
        chk("early_y_unchanged", y, 32'h44332211);
        chk("early_sel_restart", sel, 1);
        chk("early_locked", locked, 1);
        beat(8'hB2, 1'b0);
        chk("early_sync_err_one_cycle", sync_err, 0);
        beat(8'hB3, 1'b0);
        beat(8'hB4, 1'b0);
        chk("early_y", y, 32'hB4B3B2B1);

        // Back-to-back frames, sync directly after the final beat
        exp_frame_q.push_back(32'hC4C3C2C1);
        exp_frame_q.push_back(32'hD4D3D2D1);
        beat(8'hC1, 1'b1);
        beat(8'hC2, 1'b0);
        beat(8'hC3, 1'b0);
        beat(8'hC4, 1'b0);
        chk("b2b_y1", y, 32'hC4C3C2C1);
        beat(8'hD1, 1'b1);
        beat(8'hD2, 1'b0);
        beat(8'hD3, 1'b0);
        beat(8'hD4, 1'b0);
        chk("b2b_y2", y, 32'hD4D3D2D1);

        // Lost sync
        exp_err_q.push_back(1'b1);
        beat(8'h55, 1'b0);
        chk("lost_sync_err", sync_err, 1);
        chk("lost_locked", locked, 0);
        chk("lost_sel", sel, 0);
        chk("lost_y_hold", y, 32'hD4D3D2D1);
        beat(8'h66, 1'b0);
        beat(8'h77, 1'b0);
        chk("hunt_no_err", sync_err, 0);
        chk("hunt_locked", locked, 0);

        // Reset mid-frame
        beat(8'h01, 1'b1);
        beat(8'h02, 1'b0);
        chk("mid_locked_before_rst", locked, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_y", y, 0);
        chk("async_rst_sel", sel, 0);
        chk("async_rst_locked", locked, 0);
        chk("async_rst_pulses", {frame_done, sync_err}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        chk("post_rst_y", y, 0);
        chk("post_rst_locked", locked, 0);
        chk("post_rst_sel", sel, 0);

        repeat (3) idle();
        chk("frames_outstanding", exp_frame_q.size(), 0);
        chk("errs_outstanding", exp_err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
